// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions for the register file access controller.
package rv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic                  writes_rd;
    } decode_t;

    // Register fields and operand usage of one instruction word.
    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [6:0] opc;
        opc         = instr[6:0];
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.rd        = instr[11:7];
        d.uses_rs1  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
        d.uses_rs2  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
        d.writes_rd = !((opc == OPC_STORE) || (opc == OPC_BRANCH)) && (d.rd != '0);
        return d;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
module regfile_scoreboard
    import rv_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_idx,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_idx,
    input  logic [REG_ADDR_W-1:0] i_look1_idx,
    input  logic [REG_ADDR_W-1:0] i_look2_idx,
    output logic                  o_busy1,
    output logic                  o_busy2
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // Clear is applied before set so a newer claim on rd survives a same-edge retire; x0 never busy.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) begin
            w_set_mask[i_set_idx] = 1'b1;
        end
        if (i_clr_en) begin
            w_clr_mask[i_clr_idx] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy bit storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy1 = r_busy[i_look1_idx];
    assign o_busy2 = r_busy[i_look2_idx];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register file initiator: decodes rs1/rs2/rd, reads operands after the
// register file latency, hands them downstream and tracks pending writes.
module regfile_access_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned ADDR_W   = 6
)(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [31:0]       Instr,
    input  logic              InstrValid,
    output logic              InstrReady,
    output logic [ADDR_W-1:0] A1,
    output logic [ADDR_W-1:0] A2,
    input  logic [31:0]       RD1,
    input  logic [31:0]       RD2,
    output logic [31:0]       Op1,
    output logic [31:0]       Op2,
    output logic [4:0]        OpRd,
    output logic              OpValid,
    input  logic              OpReady,
    input  logic              WbValid,
    input  logic [4:0]        WbRd,
    input  logic [31:0]       WbData,
    output logic              WbReady,
    output logic [ADDR_W-1:0] A3,
    output logic [31:0]       WriteData,
    output logic              WE
);

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_use1;
    logic                  r_use2;

    decode_t               w_dec;
    logic                  w_busy1;
    logic                  w_busy2;
    logic                  w_hazard;
    logic                  w_accept;
    logic                  w_set_en;
    logic                  w_unused_instr;

    // Decode of the presented instruction word.
    always_comb begin
        w_dec = decode_instr(Instr);
    end

    assign w_unused_instr = ^{Instr[31:25], Instr[14:12]};

    assign w_hazard   = (w_dec.uses_rs1 & w_busy1) | (w_dec.uses_rs2 & w_busy2);
    assign InstrReady = Rst_n & (r_state == IDLE) & ~w_hazard;
    assign w_accept   = InstrValid & InstrReady;
    assign w_set_en   = w_accept & w_dec.writes_rd;

    // Dedicated write port: pure pass-through, x0 writes suppressed.
    assign WbReady   = 1'b1;
    assign WE        = WbValid & (WbRd != '0);
    assign A3        = ADDR_W'(WbRd);
    assign WriteData = WbData;

    // Read addresses come from the issue registers so they stay put for the whole read window.
    assign A1 = ADDR_W'(r_rs1);
    assign A2 = ADDR_W'(r_rs2);

    regfile_scoreboard u_scoreboard (
        .i_clk       (Clk),
        .i_rst_n     (Rst_n),
        .i_set_en    (w_set_en),
        .i_set_idx   (w_dec.rd),
        .i_clr_en    (WE),
        .i_clr_idx   (WbRd),
        .i_look1_idx (w_dec.rs1),
        .i_look2_idx (w_dec.rs2),
        .o_busy1     (w_busy1),
        .o_busy2     (w_busy2)
    );

    // Issue / read-wait / hold sequencer with registered operand outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_use1  <= 1'b0;
            r_use2  <= 1'b0;
            Op1     <= '0;
            Op2     <= '0;
            OpRd    <= '0;
            OpValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rs1   <= w_dec.rs1;
                        r_rs2   <= w_dec.rs2;
                        r_rd    <= w_dec.writes_rd ? w_dec.rd : '0;
                        r_use1  <= w_dec.uses_rs1;
                        r_use2  <= w_dec.uses_rs2;
                        r_cnt   <= 3'(READ_LAT - 1);
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (r_cnt == '0) begin
                        Op1     <= r_use1 ? RD1 : '0;
                        Op2     <= r_use2 ? RD2 : '0;
                        OpRd    <= r_rd;
                        OpValid <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (OpReady) begin
                        OpValid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    OpValid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
